// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS datapath: fetch, decode, execute, memory and writeback sequencing.
// Latency: strobes are decoded combinationally from the registered state and the latched IR fields.
// Backpressure: FETCH/MEM_RD/MEM_WR wait on memReady_i and abort to FETCH after MEM_TIMEOUT wait cycles.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to park unknown opcodes in TRAP until reset.

module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       rotation_i,
    input  logic       zero_i,
    input  logic       memReady_i,
    output logic       pcWrite_o,
    output logic       pcSrc_o,
    output logic       irWrite_o,
    output logic       iorD_o,
    output logic       memRead_o,
    output logic       memWrite_o,
    output logic       regWrite_o,
    output logic       regDst_o,
    output logic       memToReg_o,
    output logic       aluSrcA_o,
    output logic       aluSrcB_o,
    output logic [3:0] aluOp_o,
    output logic       instrDone_o,
    output logic       memErr_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_ALU = 4'd6,
        S_WB_MEM = 4'd7,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9
`else
        S_BRANCH = 4'd8
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [5:0]      r_opcode;
    logic [5:0]      r_funct;
    logic            r_rotation;
    logic [TO_W-1:0] r_wait_cnt;

    logic       w_mem_state;
    logic       w_timeout;
    logic [3:0] w_alu_op;
    logic       w_alu_src_a;
    logic       w_alu_src_b;

    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_ir_write;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_src_a;
    logic       w_src_b;
    logic [3:0] w_op;
    logic       w_done;
    logic       w_err;

    // States that issue a memory access and therefore run the wait counter
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout   = w_mem_state && !memReady_i && (r_wait_cnt == TIMEOUT_VAL);

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the IR fields while decoding so later states see a stable instruction
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_opcode   <= '0;
            r_funct    <= '0;
            r_rotation <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_opcode   <= opcode_i;
            r_funct    <= funct_i;
            r_rotation <= rotation_i;
        end
    end

    // Wait counter: counts stalled cycles; any exit (ready or timeout) or non-memory state clears it
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wait_cnt <= '0;
        end else if (w_mem_state && !memReady_i && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // ALU control decode from the latched instruction fields
    always_comb begin
        w_alu_op    = 4'b0000;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 1'b0;
        case (r_opcode)
            OP_RTYPE: begin
                case (r_funct)
                    FN_SLL: begin
                        w_alu_op    = 4'b1000;
                        w_alu_src_a = 1'b1;
                    end
                    FN_SRL: begin
                        w_alu_op    = r_rotation ? 4'b1011 : 4'b1001;
                        w_alu_src_a = 1'b1;
                    end
                    default: w_alu_op = 4'b0010;
                endcase
            end
            OP_ADDI: begin
                w_alu_op    = 4'b0011;
                w_alu_src_b = 1'b1;
            end
            OP_ANDI: begin
                w_alu_op    = 4'b0100;
                w_alu_src_b = 1'b1;
            end
            OP_ORI: begin
                w_alu_op    = 4'b0101;
                w_alu_src_b = 1'b1;
            end
            OP_SLTI: begin
                w_alu_op    = 4'b0110;
                w_alu_src_b = 1'b1;
            end
            OP_XORI: begin
                w_alu_op    = 4'b0111;
                w_alu_src_b = 1'b1;
            end
            OP_LW, OP_SW: begin
                w_alu_op    = 4'b0000;
                w_alu_src_b = 1'b1;
            end
            OP_BEQ: w_alu_op = 4'b0001;
            default: w_alu_op = 4'b0000;
        endcase
    end

    // Next-state and per-state datapath strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_src_a      = 1'b0;
        w_src_b      = 1'b0;
        w_op         = 4'b0000;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (memReady_i) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_BEQ: w_state_nxt = S_BRANCH;
                    OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI, OP_LW, OP_SW:
                        w_state_nxt = S_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default: w_state_nxt = S_TRAP;
`else
                    default: w_state_nxt = S_FETCH;
`endif
                endcase
            end
            S_EXEC: begin
                w_src_a = w_alu_src_a;
                w_src_b = w_alu_src_b;
                w_op    = w_alu_op;
                case (r_opcode)
                    OP_LW:   w_state_nxt = S_MEM_RD;
                    OP_SW:   w_state_nxt = S_MEM_WR;
                    default: w_state_nxt = S_WB_ALU;
                endcase
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (memReady_i) begin
                    w_state_nxt = S_WB_MEM;
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_MEM_WR: begin
                w_iord = 1'b1;
                // Withdraw the write on the abort cycle so a late memory cannot commit it
                w_mem_write = !w_timeout;
                if (memReady_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_WB_ALU: begin
                w_reg_write = 1'b1;
                w_reg_dst   = (r_opcode == OP_RTYPE);
                w_src_a     = w_alu_src_a;
                w_src_b     = w_alu_src_b;
                w_op        = w_alu_op;
                w_done      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_WB_MEM: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_src_a      = w_alu_src_a;
                w_src_b      = w_alu_src_b;
                w_op         = w_alu_op;
                w_done       = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                w_op        = 4'b0001;
                w_pc_write  = zero_i;
                w_pc_src    = zero_i;
                w_done      = 1'b1;
                w_state_nxt = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: w_state_nxt = S_TRAP;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign pcWrite_o   = w_pc_write;
    assign pcSrc_o     = w_pc_src;
    assign irWrite_o   = w_ir_write;
    assign iorD_o      = w_iord;
    assign memRead_o   = w_mem_read;
    assign memWrite_o  = w_mem_write;
    assign regWrite_o  = w_reg_write;
    assign regDst_o    = w_reg_dst;
    assign memToReg_o  = w_mem_to_reg;
    assign aluSrcA_o   = w_src_a;
    assign aluSrcB_o   = w_src_b;
    assign aluOp_o     = w_op;
    assign instrDone_o = w_done;
    assign memErr_o    = w_err;
    assign state_o     = r_state;

endmodule
